router_fifo: RTL and testbench



---
 rtl/router_pkg.sv | 19 +
 rtl/router_fifo_ptr.sv | 51 +++++
 rtl/router_fifo.sv | 88 ++++++++
 tb/tb_router_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants for the router 1x3 output FIFOs.
// Word layout: header marker above the data byte; header length in bits 7:2.
package router_pkg;

    localparam int WIDTH      = 8;
    localparam int DEPTH_LOG2 = 4;
    localparam int MARK_BIT   = WIDTH;
    localparam int LEN_HI     = 7;
    localparam int LEN_LO     = 2;
    localparam int CNT_W      = 7;

    // Bytes left in a packet once its header has been read: payload + parity.
    function automatic logic [CNT_W-1:0] pkt_count(
        input logic [LEN_HI-LEN_LO:0] len
    );
        return CNT_W'(len) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo_ptr.sv
// Read/write pointers with an extra wrap bit; produces full/empty and
// the accepted-request strobes used by the FIFO storage.
module router_fifo_ptr
    import router_pkg::*;
#(
    parameter int AW = DEPTH_LOG2
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          write_req,
    input  logic          read_req,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic          write_ok,
    output logic          read_ok,
    output logic          full,
    output logic          empty
);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign wr_addr = wr_ptr[AW-1:0];
    assign rd_addr = rd_ptr[AW-1:0];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                && (wr_ptr[AW] != rd_ptr[AW]);

    // Both strobes use pre-edge flags, so a full FIFO drops a paired write
    // and an empty one ignores a paired read.
    assign write_ok = write_req && !full;
    assign read_ok  = read_req && !empty;

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr <= '0;
        end else if (write_ok) begin
            wr_ptr <= wr_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            rd_ptr <= '0;
        end else if (read_ok) begin
            rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

endmodule

// File: rtl/router_fifo.sv
// Per-port output FIFO of the router 1x3: stores bytes with a header
// marker and tracks how much of the current packet is still unread.
module router_fifo
    import router_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int AW = DEPTH_LOG2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         soft_reset,
    input  logic         write_enb,
    input  logic         read_enb,
    input  logic         lfd_state,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         empty,
    output logic         full,
    output logic         pkt_active
);

    logic              clear;
    logic              lfd_d;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic              write_ok;
    logic              read_ok;
    logic [W:0]        rd_word;
    logic [CNT_W-1:0]  count;
    logic [W:0]        mem [2**AW];

    assign clear = reset || soft_reset;

    router_fifo_ptr #(
        .AW(AW)
    ) u_ptr (
        .clock    (clock),
        .clear    (clear),
        .write_req(write_enb),
        .read_req (read_enb),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .write_ok (write_ok),
        .read_ok  (read_ok),
        .full     (full),
        .empty    (empty)
    );

    // The header byte arrives one cycle after lfd_state, hence the delay.
    always_ff @(posedge clock) begin
        if (clear) begin
            lfd_d <= 1'b0;
        end else begin
            lfd_d <= lfd_state;
        end
    end

    always_ff @(posedge clock) begin
        if (write_ok && !clear) begin
            mem[wr_addr] <= {lfd_d, data_in};
        end
    end

    assign rd_word = mem[rd_addr];

    always_ff @(posedge clock) begin
        if (clear) begin
            data_out <= '0;
        end else if (read_ok) begin
            data_out <= rd_word[W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (read_ok) begin
            if (rd_word[W]) begin
                count <= pkt_count(rd_word[LEN_HI:LEN_LO]);
            end else if (count != '0) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign pkt_active = (count != '0);

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       pkt_active;

    int errors = 0;
    int checks = 0;

    router_fifo dut (
        .clock     (clock),
        .reset     (reset),
        .soft_reset(soft_reset),
        .write_enb (write_enb),
        .read_enb  (read_enb),
        .lfd_state (lfd_state),
        .data_in   (data_in),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .pkt_active(pkt_active)
    );

    always #5 clock = ~clock;

    // Reference model: a queue of {marker, byte} plus bytes left in packet.
    logic [8:0] q[$];
    int         m_left = 0;
    logic [7:0] m_dout = 8'h00;
    logic       m_lfd = 1'b0;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic we,
                              input logic re, input logic lfd,
                              input logic [7:0] din);
        bit was_full;
        bit was_empty;
        logic [8:0] w;
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        if (r || s) begin
            q.delete();
            m_left = 0;
            m_dout = 8'h00;
            m_lfd  = 1'b0;
        end else begin
            if (re && !was_empty) begin
                w = q.pop_front();
                m_dout = w[7:0];
                if (w[8]) m_left = int'(w[7:2]) + 1;
                else if (m_left > 0) m_left = m_left - 1;
            end
            if (we && !was_full) q.push_back({m_lfd, din});
            m_lfd = lfd;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic we,
                        input logic re, input logic lfd,
                        input logic [7:0] din);
        @(negedge clock);
        reset = r;
        soft_reset = s;
        write_enb = we;
        read_enb = re;
        lfd_state = lfd;
        data_in = din;
        @(posedge clock);
        model_edge(r, s, we, re, lfd, din);
        #1;
        chk("m_dout", data_out, m_dout);
        chk("m_empty", 8'(empty), 8'(q.size() == 0));
        chk("m_full", 8'(full), 8'(q.size() == 16));
        chk("m_active", 8'(pkt_active), 8'(m_left != 0));
    endtask

    task automatic wr(input logic [7:0] d);
        step(0, 0, 1, 0, 0, d);
    endtask

    task automatic rd();
        step(0, 0, 0, 1, 0, 8'h00);
    endtask

    typedef struct {
        logic       r, s, we, re, lfd;
        logic [7:0] din;
        logic [7:0] dout;
        logic       emp, ful, act;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic r, logic s, logic we, logic re,
                                logic lfd, logic [7:0] din, logic [7:0] dout,
                                logic emp, logic ful, logic act);
        vec_t v;
        v.r = r; v.s = s; v.we = we; v.re = re; v.lfd = lfd;
        v.din = din; v.dout = dout; v.emp = emp; v.ful = ful; v.act = act;
        return v;
    endfunction

    initial begin
        // Reset, then one packet: header 0x0C (len 3), 3 payload, parity.
        tbl[0]  = mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0, 8'h0C, 8'h00, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 0, 8'h11, 8'h00, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 0, 0, 8'h22, 8'h00, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 0, 8'h33, 8'h00, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 8'h3C, 8'h00, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 0, 8'h00, 8'h0C, 0, 0, 1);
        tbl[8]  = mk(0, 0, 0, 1, 0, 8'h00, 8'h11, 0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 1, 0, 8'h00, 8'h22, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 1, 0, 8'h00, 8'h33, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 1, 0, 8'h00, 8'h3C, 1, 0, 0);
        tbl[12] = mk(0, 0, 0, 1, 0, 8'h00, 8'h3C, 1, 0, 0);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].we, tbl[i].re, tbl[i].lfd,
                 tbl[i].din);
            chk($sformatf("vec%0d_dout", i), data_out, tbl[i].dout);
            chk($sformatf("vec%0d_empty", i), 8'(empty), 8'(tbl[i].emp));
            chk($sformatf("vec%0d_full", i), 8'(full), 8'(tbl[i].ful));
            chk($sformatf("vec%0d_active", i), 8'(pkt_active),
                8'(tbl[i].act));
        end

        // Full boundary and dropped 17th write.
        step(1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) wr(8'(i));
        chk("full_after16", 8'(full), 8'h01);
        wr(8'hFF);
        chk("full_drop", 8'(full), 8'h01);
        for (int i = 0; i < 16; i++) begin
            rd();
            chk($sformatf("full_rd%0d", i), data_out, 8'(i));
        end
        chk("full_drained", 8'(empty), 8'h01);

        // Simultaneous read and write while full: write must be dropped.
        for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i));
        step(0, 0, 1, 1, 0, 8'hAA);
        chk("sim_dout", data_out, 8'h40);
        chk("sim_full", 8'(full), 8'h00);
        for (int i = 0; i < 15; i++) begin
            rd();
            chk($sformatf("sim_rd%0d", i), data_out, 8'h41 + 8'(i));
        end
        chk("sim_count15", 8'(empty), 8'h01);

        // Read and write together on empty: only the write lands.
        step(0, 0, 1, 1, 0, 8'h5A);
        chk("emp_rw_dout", data_out, 8'h4F);
        rd();
        chk("emp_rw_data", data_out, 8'h5A);

        // Pointer wrap: three rounds of 10 writes then 10 reads.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) wr(8'(k * 16 + i));
            chk($sformatf("wrap%0d_notfull", k), 8'(full), 8'h00);
            for (int i = 0; i < 10; i++) begin
                rd();
                chk($sformatf("wrap%0d_rd%0d", k, i), data_out,
                    8'(k * 16 + i));
            end
            chk($sformatf("wrap%0d_empty", k), 8'(empty), 8'h01);
        end

        // Soft reset mid-packet, then a fresh packet.
        step(0, 0, 0, 0, 1, 8'h00);
        wr(8'h0C); wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h3C);
        rd(); rd(); rd();
        chk("sr_before_active", 8'(pkt_active), 8'h01);
        step(0, 1, 0, 0, 0, 8'h00);
        chk("sr_empty", 8'(empty), 8'h01);
        chk("sr_active", 8'(pkt_active), 8'h00);
        chk("sr_dout", data_out, 8'h00);
        step(0, 0, 0, 0, 1, 8'h00);
        wr(8'h08); wr(8'hAA); wr(8'hBB); wr(8'h11);
        rd();
        chk("sr_new_hdr", data_out, 8'h08);
        chk("sr_new_active", 8'(pkt_active), 8'h01);
        rd();
        chk("sr_new_p0", data_out, 8'hAA);
        rd();
        chk("sr_new_p1", data_out, 8'hBB);
        rd();
        chk("sr_new_par", data_out, 8'h11);
        chk("sr_new_done", 8'(pkt_active), 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(1'b0, ($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
